// File: rtl/climate_state_encoder.sv
// Classifies each temperature sample into a 6-bit zone address {temp, change, dwell}
// using runtime-loadable thresholds and a setpoint dwell counter.
module climate_state_encoder #(
    parameter int TEMP_W      = 7,
    parameter int TIME_W      = 6,
    parameter int CHG_W       = 8,
    parameter int DEF_LB_TEMP = 18,
    parameter int DEF_UB_TEMP = 24,
    parameter int DEF_LB_TIME = 4,
    parameter int DEF_UB_TIME = 32,
    parameter int DEF_LB_CHG  = 2,
    parameter int DEF_UB_CHG  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [TEMP_W-1:0] temp,
    input  logic [TEMP_W-1:0] desired_temp,
    input  logic              cfg_we,
    input  logic [TEMP_W-1:0] cfg_lb_temp,
    input  logic [TEMP_W-1:0] cfg_ub_temp,
    input  logic [TIME_W-1:0] cfg_lb_time,
    input  logic [TIME_W-1:0] cfg_ub_time,
    input  logic [CHG_W-1:0]  cfg_lb_chg,
    input  logic [CHG_W-1:0]  cfg_ub_chg,
    output logic [5:0]        addr_out,
    output logic              addr_valid,
    output logic [TIME_W-1:0] dwell_count,
    output logic              cfg_err
);

    localparam int DW = ((TEMP_W > CHG_W) ? TEMP_W : CHG_W) + 2;

    logic [TEMP_W-1:0] lbTemp_q, lbTemp_d, ubTemp_q, ubTemp_d;
    logic [TIME_W-1:0] lbTime_q, lbTime_d, ubTime_q, ubTime_d;
    logic [CHG_W-1:0]  lbChg_q, lbChg_d, ubChg_q, ubChg_d;
    logic [TIME_W-1:0] count_q, count_d;
    logic [TEMP_W-1:0] lastDesired_q, lastDesired_d;
    logic              havePrev_q, havePrev_d;
    logic [5:0]        addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic signed [DW-1:0] diff, ubChgS, negLbChgS;
    logic [TIME_W-1:0]    cntNext;
    logic [1:0]           tempZone, chgZone, timeZone;
    logic                 cfgOk;

    // Both operands are zero-extended into a wider signed space so the difference never wraps.
    assign diff      = $signed(DW'(temp)) - $signed(DW'(desired_temp));
    assign ubChgS    = $signed(DW'(ubChg_q));
    assign negLbChgS = -$signed(DW'(lbChg_q));

    assign cfgOk = (cfg_lb_temp < cfg_ub_temp) && (cfg_lb_time < cfg_ub_time);

    always_comb begin
        tempZone = 2'b10;
        if (temp <= lbTemp_q) begin
            tempZone = 2'b01;
        end else if (temp >= ubTemp_q) begin
            tempZone = 2'b11;
        end

        chgZone = 2'b10;
        if (diff > ubChgS) begin
            chgZone = 2'b01;
        end else if (diff < negLbChgS) begin
            chgZone = 2'b11;
        end

        // A new or first setpoint restarts dwell; otherwise count up and stick at all-ones.
        cntNext = '0;
        if (havePrev_q && (desired_temp == lastDesired_q)) begin
            cntNext = (count_q == '1) ? count_q : count_q + TIME_W'(1);
        end

        timeZone = 2'b10;
        if (cntNext <= lbTime_q) begin
            timeZone = 2'b01;
        end else if (cntNext >= ubTime_q) begin
            timeZone = 2'b11;
        end
    end

    always_comb begin
        lbTemp_d      = lbTemp_q;
        ubTemp_d      = ubTemp_q;
        lbTime_d      = lbTime_q;
        ubTime_d      = ubTime_q;
        lbChg_d       = lbChg_q;
        ubChg_d       = ubChg_q;
        count_d       = count_q;
        lastDesired_d = lastDesired_q;
        havePrev_d    = havePrev_q;
        addr_d        = addr_q;
        valid_d       = 1'b0;
        err_d         = err_q;

        if (in_valid) begin
            addr_d        = {tempZone, chgZone, timeZone};
            count_d       = cntNext;
            lastDesired_d = desired_temp;
            havePrev_d    = 1'b1;
            valid_d       = 1'b1;
        end

        // Thresholds load as one set; the sample on this same edge already used the old set.
        if (cfg_we) begin
            if (cfgOk) begin
                lbTemp_d = cfg_lb_temp;
                ubTemp_d = cfg_ub_temp;
                lbTime_d = cfg_lb_time;
                ubTime_d = cfg_ub_time;
                lbChg_d  = cfg_lb_chg;
                ubChg_d  = cfg_ub_chg;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lbTemp_q      <= TEMP_W'(DEF_LB_TEMP);
            ubTemp_q      <= TEMP_W'(DEF_UB_TEMP);
            lbTime_q      <= TIME_W'(DEF_LB_TIME);
            ubTime_q      <= TIME_W'(DEF_UB_TIME);
            lbChg_q       <= CHG_W'(DEF_LB_CHG);
            ubChg_q       <= CHG_W'(DEF_UB_CHG);
            count_q       <= '0;
            lastDesired_q <= '0;
            havePrev_q    <= 1'b0;
            addr_q        <= '0;
            valid_q       <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            lbTemp_q      <= lbTemp_d;
            ubTemp_q      <= ubTemp_d;
            lbTime_q      <= lbTime_d;
            ubTime_q      <= ubTime_d;
            lbChg_q       <= lbChg_d;
            ubChg_q       <= ubChg_d;
            count_q       <= count_d;
            lastDesired_q <= lastDesired_d;
            havePrev_q    <= havePrev_d;
            addr_q        <= addr_d;
            valid_q       <= valid_d;
            err_q         <= err_d;
        end
    end

    assign addr_out    = addr_q;
    assign addr_valid  = valid_q;
    assign dwell_count = count_q;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_climate_state_encoder.sv
// Scoreboard bench for climate_state_encoder: a behavioural model predicts each
// sample's zone address and dwell, which are compared when addr_valid appears.
module tb_climate_state_encoder;

    typedef struct {
        logic [5:0] addr;
        logic [5:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [6:0] temp, desired_temp;
    logic       cfg_we;
    logic [6:0] cfg_lb_temp, cfg_ub_temp;
    logic [5:0] cfg_lb_time, cfg_ub_time;
    logic [7:0] cfg_lb_chg, cfg_ub_chg;
    logic [5:0] addr_out;
    logic       addr_valid;
    logic [5:0] dwell_count;
    logic       cfg_err;

    int checks = 0;
    int passed = 0;

    exp_t sb[$];

    int  mLbTemp, mUbTemp, mLbTime, mUbTime, mLbChg, mUbChg;
    int  mCnt, mLast;
    bit  mHavePrev, mErr;

    climate_state_encoder dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .temp        (temp),
        .desired_temp(desired_temp),
        .cfg_we      (cfg_we),
        .cfg_lb_temp (cfg_lb_temp),
        .cfg_ub_temp (cfg_ub_temp),
        .cfg_lb_time (cfg_lb_time),
        .cfg_ub_time (cfg_ub_time),
        .cfg_lb_chg  (cfg_lb_chg),
        .cfg_ub_chg  (cfg_ub_chg),
        .addr_out    (addr_out),
        .addr_valid  (addr_valid),
        .dwell_count (dwell_count),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        mLbTemp = 18; mUbTemp = 24; mLbTime = 4; mUbTime = 32; mLbChg = 2; mUbChg = 2;
        mCnt = 0; mLast = 0; mHavePrev = 0; mErr = 0;
        sb.delete();
    endtask

    // One clock: optionally a sample and/or a config write, then check what came out.
    task automatic cycle(input bit v, input int t, input int d, input bit we);
        exp_t e;
        int   tz, cz, tmz, df, nc;
        if (v) begin
            tz = (t <= mLbTemp) ? 1 : ((t >= mUbTemp) ? 3 : 2);
            df = t - d;
            cz = (df > mUbChg) ? 1 : ((df < -mLbChg) ? 3 : 2);
            nc = (!mHavePrev || d != mLast) ? 0 : ((mCnt + 1 > 63) ? 63 : mCnt + 1);
            tmz = (nc <= mLbTime) ? 1 : ((nc >= mUbTime) ? 3 : 2);
            e.addr = 6'(tz * 16 + cz * 4 + tmz);
            e.cnt  = 6'(nc);
            sb.push_back(e);
            mCnt = nc; mLast = d; mHavePrev = 1;
        end
        if (we) begin
            if (int'(cfg_lb_temp) < int'(cfg_ub_temp) && int'(cfg_lb_time) < int'(cfg_ub_time)) begin
                mLbTemp = int'(cfg_lb_temp); mUbTemp = int'(cfg_ub_temp);
                mLbTime = int'(cfg_lb_time); mUbTime = int'(cfg_ub_time);
                mLbChg  = int'(cfg_lb_chg);  mUbChg  = int'(cfg_ub_chg);
            end else begin
                mErr = 1;
            end
        end
        in_valid = v; temp = 7'(t); desired_temp = 7'(d); cfg_we = we;
        @(posedge clk);
        #1;
        in_valid = 0; cfg_we = 0;
        checks++;
        if (addr_valid !== v) $display("[TB] FAIL addr_valid: got %b want %b", addr_valid, v);
        else passed++;
        if (v && sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (addr_out !== e.addr) $display("[TB] FAIL addr_out: got %b want %b", addr_out, e.addr);
            else passed++;
            checks++;
            if (dwell_count !== e.cnt) $display("[TB] FAIL dwell: got %0d want %0d", dwell_count, e.cnt);
            else passed++;
        end
        checks++;
        if (cfg_err !== mErr) $display("[TB] FAIL cfg_err: got %b want %b", cfg_err, mErr);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 0; cfg_we = 0; temp = 0; desired_temp = 0;
        cfg_lb_temp = 0; cfg_ub_temp = 0; cfg_lb_time = 0; cfg_ub_time = 0; cfg_lb_chg = 0; cfg_ub_chg = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        modelReset();
        checks++;
        if (addr_out !== 6'b0 || addr_valid !== 1'b0 || dwell_count !== 6'd0 || cfg_err !== 1'b0)
            $display("[TB] FAIL reset_state: got addr=%b v=%b dwell=%0d err=%b want 0/0/0/0",
                     addr_out, addr_valid, dwell_count, cfg_err);
        else passed++;
    endtask

    task automatic test_defaults();
        cycle(1, 21, 21, 0);
        checks++;
        if (addr_out !== 6'b10_10_01) $display("[TB] FAIL default_addr: got %b want 101001", addr_out);
        else passed++;
        cycle(0, 0, 0, 0);
        checks++;
        if (addr_out !== 6'b10_10_01) $display("[TB] FAIL hold_addr: got %b want 101001", addr_out);
        else passed++;
    endtask

    task automatic test_dwell();
        for (int i = 0; i < 39; i++) cycle(1, 21, 21, 0);
        checks++;
        if (dwell_count !== 6'd39 || addr_out[1:0] !== 2'b11)
            $display("[TB] FAIL dwell_39: got %0d zone %b want 39 zone 11", dwell_count, addr_out[1:0]);
        else passed++;
        cycle(1, 21, 22, 0);
        checks++;
        if (dwell_count !== 6'd0 || addr_out[1:0] !== 2'b01)
            $display("[TB] FAIL setpoint_change: got %0d zone %b want 0 zone 01", dwell_count, addr_out[1:0]);
        else passed++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 70; i++) cycle(1, 22, 22, 0);
        checks++;
        if (dwell_count !== 6'd63) $display("[TB] FAIL saturation: got %0d want 63", dwell_count);
        else passed++;
    endtask

    task automatic test_change();
        cycle(1, 18, 20, 0);
        checks++;
        if (addr_out[5:4] !== 2'b01) $display("[TB] FAIL temp_lb_edge: got %b want 01", addr_out[5:4]);
        else passed++;
        cycle(1, 24, 20, 0);
        checks++;
        if (addr_out[5:4] !== 2'b11) $display("[TB] FAIL temp_ub_edge: got %b want 11", addr_out[5:4]);
        else passed++;
        cycle(1, 23, 20, 0);
        checks++;
        if (addr_out[3:2] !== 2'b01) $display("[TB] FAIL chg_high: got %b want 01", addr_out[3:2]);
        else passed++;
        cycle(1, 17, 20, 0);
        checks++;
        if (addr_out[3:2] !== 2'b11) $display("[TB] FAIL chg_low: got %b want 11", addr_out[3:2]);
        else passed++;
        cycle(1, 22, 20, 0);
        checks++;
        if (addr_out[3:2] !== 2'b10) $display("[TB] FAIL chg_edge: got %b want 10", addr_out[3:2]);
        else passed++;
        cycle(1, 0, 127, 0);
        cycle(1, 127, 0, 0);
    endtask

    task automatic test_cfg();
        cfg_lb_temp = 30; cfg_ub_temp = 20; cfg_lb_time = 1; cfg_ub_time = 3; cfg_lb_chg = 5; cfg_ub_chg = 5;
        cycle(0, 0, 0, 1);
        checks++;
        if (cfg_err !== 1'b1) $display("[TB] FAIL cfg_reject: got %b want 1", cfg_err);
        else passed++;
        cycle(1, 21, 21, 0);
        cfg_lb_temp = 22; cfg_ub_temp = 26;
        cycle(1, 22, 21, 1);
        checks++;
        if (addr_out[5:2] !== 4'b1010) $display("[TB] FAIL cfg_old_used: got %b want 1010", addr_out[5:2]);
        else passed++;
        cycle(1, 22, 21, 0);
        checks++;
        if (addr_out[5:4] !== 2'b01) $display("[TB] FAIL cfg_new_used: got %b want 01", addr_out[5:4]);
        else passed++;
    endtask

    task automatic test_reset_midstream();
        rst = 1; in_valid = 1; temp = 21; desired_temp = 21; cfg_we = 1;
        @(posedge clk);
        #1;
        rst = 0; in_valid = 0; cfg_we = 0;
        modelReset();
        checks++;
        if (addr_valid !== 1'b0 || dwell_count !== 6'd0 || addr_out !== 6'b0 || cfg_err !== 1'b0)
            $display("[TB] FAIL midstream_reset: got v=%b dwell=%0d addr=%b err=%b want 0/0/0/0",
                     addr_valid, dwell_count, addr_out, cfg_err);
        else passed++;
        cycle(1, 21, 21, 0);
        checks++;
        if (dwell_count !== 6'd0) $display("[TB] FAIL post_reset_dwell: got %0d want 0", dwell_count);
        else passed++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            cycle(1, $urandom_range(0, 127), (i < 10) ? 25 : $urandom_range(24, 26), 0);
            if (i % 7 == 6) cycle(0, 0, 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_dwell();
        test_saturation();
        test_change();
        test_cfg();
        test_reset_midstream();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/climate_state_encoder.md
CLIMATE_STATE_ENCODER -- requirements
Module: climate_state_encoder

Interface
REQ-001 SHALL take parameter TEMP_W, default 7: width of temp, desired_temp and temperature thresholds.
REQ-002 SHALL take parameter TIME_W, default 6: width of dwell counter and time thresholds.
REQ-003 SHALL take parameter CHG_W, default 8: width of change thresholds.
REQ-004 SHALL take parameters DEF_LB_TEMP=18, DEF_UB_TEMP=24, DEF_LB_TIME=4, DEF_UB_TIME=32, DEF_LB_CHG=2, DEF_UB_CHG=2: threshold reset values.
REQ-005 SHALL have clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have in_valid  input  1  sample strobe.
REQ-008 SHALL have temp, desired_temp  input  TEMP_W  unsigned measured and requested temperature.
REQ-009 SHALL have cfg_we  input  1  threshold load strobe.
REQ-010 SHALL have cfg_lb_temp, cfg_ub_temp (TEMP_W), cfg_lb_time, cfg_ub_time (TIME_W), cfg_lb_chg, cfg_ub_chg (CHG_W)  input  threshold values.
REQ-011 SHALL have addr_out  output  6  registered {temp_zone, chg_zone, time_zone}, 2 bits each.
REQ-012 SHALL have addr_valid  output  1  one-cycle pulse marking a new addr_out.
REQ-013 SHALL have dwell_count  output  TIME_W  current dwell counter.
REQ-014 SHALL have cfg_err  output  1  sticky flag for rejected configuration.

Function
REQ-015 SHALL encode each zone: 2'b01 low, 2'b10 mid, 2'b11 high; 2'b00 never produced while addr_valid is 1.
REQ-016 SHALL set temp_zone: temp <= lb_temp -> 01; else temp >= ub_temp -> 11; else 10 (low check has priority).
REQ-017 SHALL compute diff = temp - desired_temp as signed, width max(TEMP_W,CHG_W)+2, with no wrap.
REQ-018 SHALL set chg_zone: diff > ub_chg -> 01; else diff < -lb_chg -> 11; else 10.
REQ-019 SHALL hold dwell state as a counter plus last desired_temp plus a have_prev flag.
REQ-020 SHALL, on in_valid, compute cnt_next = 0 if have_prev is 0 or desired_temp != last desired; else the counter +1, saturating at all-ones (no wrap).
REQ-021 SHALL set time_zone from cnt_next: <= lb_time -> 01; else >= ub_time -> 11; else 10.
REQ-022 SHALL, on an in_valid edge, register addr_out, cnt_next and desired_temp, set have_prev, and pulse addr_valid high for exactly the following cycle (latency 1).
REQ-023 SHALL hold addr_out, the counter and the last desired value when in_valid is 0; addr_valid is then 0.
REQ-024 SHALL, on cfg_we, load all six thresholds atomically only if cfg_lb_temp < cfg_ub_temp and cfg_lb_time < cfg_ub_time; otherwise keep the old set and set cfg_err.
REQ-025 SHALL, with cfg_we and in_valid on the same edge, classify the sample with the old thresholds; new thresholds apply from the next edge.
REQ-026 SHALL clear cfg_err only on rst.

Reset
REQ-027 SHALL, on rst at any edge including mid-stream, force addr_out=0, addr_valid=0, dwell_count=0, have_prev=0, cfg_err=0, thresholds=DEF_*; rst overrides in_valid and cfg_we.
REQ-028 SHALL treat the first in_valid after reset as a setpoint change (dwell 0).

Verification
REQ-029 SHALL check defaults: temp=21, desired=21, first sample -> addr_out=6'b10_10_01, dwell 0, addr_valid high 1 cycle later.
REQ-030 SHALL check dwell: 40 consecutive samples with desired=21 -> dwell reaches 39, time_zone 11 from dwell>=32; then desired=22 -> dwell 0, time_zone 01.
REQ-031 SHALL check saturation: 70 samples with TIME_W=6, constant desired -> dwell holds 63.
REQ-032 SHALL check change/boundaries: temp=18 -> temp_zone 01; temp=24 -> 11; desired=20 with temp=23 -> chg 01, temp=17 -> chg 11, temp=22 -> chg 10.
REQ-033 SHALL check cfg: load lb_temp=30, ub_temp=20 -> cfg_err=1, zones unchanged; valid load with a simultaneous sample -> old thresholds used for that sample.
REQ-034 SHALL check reset mid-stream: rst with in_valid high -> no addr_valid pulse, dwell 0, next sample dwell 0.
